// File: rtl/program_loader.sv
// program_loader: boot-time byte-stream loader driving the CPU instruction-memory write port.
// Define PROGRAM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module program_loader #(
  parameter int HALF_WORD = 16,
  parameter int WORD = 32,
  parameter logic [WORD-1:0] BASE_ADDR = '0,
  parameter int ADDR_STEP = 2,
  parameter int MAX_HALFWORDS = 1024
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 byte_valid_i,
  input  logic [7:0]           byte_data_i,
  output logic                 byte_ready_o,
  output logic                 program_mem_write_en_o,
  output logic [HALF_WORD-1:0] instruction_o,
  output logic [WORD-1:0]      instruction_addr_o,
  output logic                 cpu_reset_o,
  output logic                 load_done_o,
  output logic                 error_o
);
  typedef enum logic [2:0] {
    S_LEN_LO, S_LEN_HI, S_DATA_LO, S_DATA_HI, S_WRITE, S_CSUM, S_DONE, S_ERROR
  } state_t;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  localparam state_t S_END = S_CSUM;
  logic [7:0] csum;
`else
  localparam state_t S_END = S_DONE;
`endif
  state_t state;
  logic [15:0] len, idx;
  logic [7:0] lo;
  logic xfer;
  logic [15:0] hdr;
  assign byte_ready_o = state inside {S_LEN_LO, S_LEN_HI, S_DATA_LO, S_DATA_HI, S_CSUM};
  assign xfer = byte_valid_i && byte_ready_o;
  assign hdr = {byte_data_i, len[7:0]};
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state <= S_LEN_LO;
      len <= '0;
      idx <= '0;
      lo <= '0;
      program_mem_write_en_o <= 1'b0;
      instruction_o <= '0;
      instruction_addr_o <= BASE_ADDR;
      cpu_reset_o <= 1'b1;
      load_done_o <= 1'b0;
      error_o <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum <= '0;
`endif
    end else begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      if (xfer) csum <= csum ^ byte_data_i;
`endif
      program_mem_write_en_o <= 1'b0;
      case (state)
        S_LEN_LO: if (xfer) begin
          len[7:0] <= byte_data_i;
          state <= S_LEN_HI;
        end
        S_LEN_HI: if (xfer) begin
          len[15:8] <= byte_data_i;
          idx <= '0;
          if (hdr == '0) begin
            state <= S_END;
            load_done_o <= S_END == S_DONE;
            cpu_reset_o <= S_END != S_DONE;
          end else if (hdr > 16'(MAX_HALFWORDS)) begin
            state <= S_ERROR;
            error_o <= 1'b1;
          end else state <= S_DATA_LO;
        end
        S_DATA_LO: if (xfer) begin
          lo <= byte_data_i;
          state <= S_DATA_HI;
        end
        S_DATA_HI: if (xfer) begin
          instruction_o <= {byte_data_i, lo};
          instruction_addr_o <= BASE_ADDR + WORD'(idx) * WORD'(ADDR_STEP);
          program_mem_write_en_o <= 1'b1;
          state <= S_WRITE;
        end
        S_WRITE: begin
          idx <= idx + 16'd1;
          if (idx == len - 16'd1) begin
            state <= S_END;
            load_done_o <= S_END == S_DONE;
            cpu_reset_o <= S_END != S_DONE;
          end else state <= S_DATA_LO;
        end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        S_CSUM: if (xfer) begin
          state <= byte_data_i == csum ? S_DONE : S_ERROR;
          load_done_o <= byte_data_i == csum;
          cpu_reset_o <= byte_data_i != csum;
          error_o <= byte_data_i != csum;
        end
`endif
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: randomized scoreboard bench for program_loader against a stream-parsing reference model.
module tb_program_loader;
  logic clk = 0, rst = 1, valid = 0;
  logic [7:0] data = 0;
  logic ready, we, cpu_rst, done, err;
  logic [15:0] instr;
  logic [31:0] addr;
  int checks = 0, errors = 0;
  typedef struct {logic [15:0] d; logic [31:0] a;} wr_t;
  wr_t expq[$];
  logic prev_we = 0;

  program_loader dut (
    .clk_i(clk), .reset_i(rst), .byte_valid_i(valid), .byte_data_i(data),
    .byte_ready_o(ready), .program_mem_write_en_o(we), .instruction_o(instr),
    .instruction_addr_o(addr), .cpu_reset_o(cpu_rst), .load_done_o(done), .error_o(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (we) begin
      chk("ready_low_in_write", ready, 0);
      chk("strobe_one_cycle", prev_we, 0);
      chk("write_expected", expq.size() != 0, 1);
      if (expq.size() != 0) begin
        wr_t w;
        w = expq.pop_front();
        chk("write_data", instr, w.d);
        chk("write_addr", addr, w.a);
      end
    end
    prev_we = we;
  end

  // Parses a byte stream as the loader should: returns 0 incomplete, 1 done, 2 error.
  task automatic model(input logic [7:0] b[$], output int oc);
    int n;
    logic [7:0] x;
    oc = 0;
    if (b.size() < 2) return;
    n = {b[1], b[0]};
    if (n > 1024) begin oc = 2; return; end
    for (int i = 0; i < n && 3 + 2 * i < b.size(); i++)
      expq.push_back('{{b[3 + 2 * i], b[2 + 2 * i]}, 32'(i * 2)});
    if (b.size() < 2 + 2 * n) return;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    if (b.size() < 3 + 2 * n) return;
    x = 0;
    for (int j = 0; j < 2 + 2 * n; j++) x ^= b[j];
    oc = x == b[2 + 2 * n] ? 1 : 2;
`else
    x = 0;
    oc = 1 + int'(x);
`endif
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t = 0;
    valid = 0;
    repeat (gap) @(negedge clk);
    valid = 1;
    data = b;
    while (!ready && t < 50) begin @(negedge clk); t++; end
    if (!ready) chk("accept_timeout", ready, 1);
    else @(negedge clk);
    valid = 0;
  endtask

  task automatic finish_check(input int oc, input string tag);
    int t = 0;
    if (oc == 0) return;
    while (!(done || err) && t < 50) begin @(negedge clk); t++; end
    chk({tag, "_terminal"}, done || err, 1);
    chk({tag, "_done"}, done, oc == 1);
    chk({tag, "_error"}, err, oc == 2);
    chk({tag, "_cpu_reset"}, cpu_rst, oc != 1);
    chk({tag, "_ready"}, ready, 0);
    chk({tag, "_writes_left"}, expq.size(), 0);
  endtask

  task automatic run(input logic [7:0] b0[$], input int gapmax, input bit auto_cs, input string tag);
    logic [7:0] b[$];
    int oc;
    logic [7:0] x;
    b = b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    if (auto_cs) begin
      x = 0;
      foreach (b[i]) x ^= b[i];
      b.push_back(x);
    end
`else
    x = {7'd0, auto_cs};
`endif
    model(b, oc);
    foreach (b[i]) send_byte(b[i], gapmax > 0 ? int'($urandom_range(0, gapmax)) : 0);
    finish_check(oc, tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    valid = 0;
    @(negedge clk);
    chk("rst_we", we, 0);
    chk("rst_instr", instr, 0);
    chk("rst_addr", addr, 0);
    chk("rst_cpu_reset", cpu_rst, 1);
    chk("rst_done", done, 0);
    chk("rst_error", err, 0);
    chk("rst_ready", ready, 1);
    expq.delete();
    rst = 0;
  endtask

  task automatic rand_stream(input int n, output logic [7:0] b[$]);
    b = {};
    b.push_back(8'(n));
    b.push_back(8'(n >> 8));
    for (int i = 0; i < 2 * n; i++) b.push_back(8'($urandom));
  endtask

  initial begin
    logic [7:0] s[$];
    int oc;
    do_reset();
    run('{8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56}, 0, 1, "two_words");
    do_reset();
    s = '{8'h00, 8'h00};
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    s.push_back(8'h00);
`endif
    model(s, oc);
    foreach (s[i]) send_byte(s[i], 0);
`ifndef PROGRAM_LOADER_CHECKSUM_EN
    chk("n0_done_next_cycle", done, 1);
`endif
    finish_check(oc, "n0");
    do_reset();
    run('{8'h01, 8'h04}, 0, 0, "too_long");
    do_reset();
    rand_stream(4, s);
    run(s, 3, 1, "gaps_n4");
    for (int k = 0; k < 6; k++) begin
      do_reset();
      rand_stream(int'($urandom_range(1, 12)), s);
      run(s, int'($urandom_range(0, 2)), 1, "rand");
    end
    do_reset();
    s = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33};
    model(s, oc);
    foreach (s[i]) send_byte(s[i], 0);
    repeat (3) @(negedge clk);
    chk("abort_writes_seen", expq.size(), 0);
    do_reset();
    run('{8'h01, 8'h00, 8'hCD, 8'hAB}, 0, 1, "after_abort");
    do_reset();
    s = '{8'h01, 8'h00, 8'hEF};
    foreach (s[i]) send_byte(s[i], 0);
    valid = 1;
    data = 8'hAB;
    rst = 1;
    @(negedge clk);
    chk("pending_write_dropped", we, 0);
    rst = 0;
    valid = 0;
    chk("restart_ready", ready, 1);
    run('{8'h01, 8'h00, 8'h22, 8'h11}, 0, 1, "after_drop");
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    do_reset();
    run('{8'h01, 8'h00, 8'hCD, 8'hAB, 8'h67}, 0, 0, "csum_ok");
    do_reset();
    run('{8'h01, 8'h00, 8'hCD, 8'hAB, 8'h66}, 0, 0, "csum_bad");
`endif
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
